// File: rtl/regfile_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// regfile_write_scheduler_pkg : RegisterFile geometry and scheduler FSM states
// Revision: 1.0
// ============================================================================
package regfile_write_scheduler_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;
    localparam int REG_NUM_REGS = 32;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETUP       = 3'd1,
        ST_STROBE      = 3'd2,
        ST_INIT_SETUP  = 3'd3,
        ST_INIT_STROBE = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : picks the first requester at or after ptr_i, wrapping around
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    int w_j;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        w_j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[w_j]) begin
                any_o          = 1'b1;
                grant_o[w_j]   = 1'b1;
                grant_idx_o    = IDX_W'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// regfile_write_scheduler : round-robin two-phase writer for the RegisterFile
// Revision: 1.0
// ============================================================================
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int                NUM_REQ    = 4,
    parameter int                ADDR_W     = REG_ADDR_W,
    parameter int                DATA_W     = REG_DATA_W,
    parameter int                NUM_REGS   = REG_NUM_REGS,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int                IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        init_start_i,
    output logic                        init_busy_o,
    output logic                        rf_write_o,
    output logic [ADDR_W-1:0]           rf_register_no_o,
    output logic [DATA_W-1:0]           rf_reg_data_o,
    output logic                        wr_done_o,
    output logic [IDX_W-1:0]            wr_done_id_o
);

    sched_state_t          state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      id_q;
    logic [ADDR_W-1:0]     cnt_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  rf_write_q;
    logic                  init_busy_q;
    logic                  wr_done_q;
    logic [IDX_W-1:0]      wr_done_id_q;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic                  w_any;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_ptr_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_gnt_idx),
        .any_o       (w_any)
    );

    assign w_accept = (state_q == ST_IDLE) || (state_q == ST_STROBE);
    assign w_ptr_d  = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // init_start pre-empts requesters, so no grant is shown while it is high
    assign req_ready_o = (!reset_i && w_accept && !init_start_i) ? w_grant : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rf_write_q   <= 1'b0;
            init_busy_q  <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_done_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_STROBE: begin
                    rf_write_q <= 1'b0;
                    wr_done_q  <= 1'b0;
                    if (init_start_i) begin
                        cnt_q       <= '0;
                        addr_q      <= '0;
                        data_q      <= INIT_VALUE;
                        init_busy_q <= 1'b1;
                        state_q     <= ST_INIT_SETUP;
                    end else if (w_any) begin
                        addr_q  <= req_addr_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
                        data_q  <= req_data_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
                        id_q    <= w_gnt_idx;
                        ptr_q   <= w_ptr_d;
                        state_q <= ST_SETUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    rf_write_q   <= 1'b1;
                    wr_done_q    <= 1'b1;
                    wr_done_id_q <= id_q;
                    state_q      <= ST_STROBE;
                end
                ST_INIT_SETUP: begin
                    rf_write_q <= 1'b1;
                    state_q    <= ST_INIT_STROBE;
                end
                ST_INIT_STROBE: begin
                    rf_write_q <= 1'b0;
                    if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                        init_busy_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        addr_q  <= cnt_q + 1'b1;
                        state_q <= ST_INIT_SETUP;
                    end
                end
                default: begin
                    rf_write_q  <= 1'b0;
                    wr_done_q   <= 1'b0;
                    init_busy_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rf_write_o       = rf_write_q;
    assign rf_register_no_o = addr_q;
    assign rf_reg_data_o    = data_q;
    assign init_busy_o      = init_busy_q;
    assign wr_done_o        = wr_done_q;
    assign wr_done_id_o     = wr_done_id_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// tb_regfile_write_scheduler : directed bench with write scoreboard and RF model
// Revision: 1.0
// ============================================================================
module tb_regfile_write_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*5-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           init_start;
    logic           init_busy;
    logic           rf_write;
    logic [4:0]     rf_register_no;
    logic [31:0]    rf_reg_data;
    logic           wr_done;
    logic [1:0]     wr_done_id;

    typedef struct packed {
        logic [1:0]  id;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] regs[32];
    logic        prev_write = 1'b0;
    int          errors = 0;
    int          checks = 0;

    regfile_write_scheduler dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .req_valid_i      (req_valid),
        .req_addr_i       (req_addr),
        .req_data_i       (req_data),
        .req_ready_o      (req_ready),
        .init_start_i     (init_start),
        .init_busy_o      (init_busy),
        .rf_write_o       (rf_write),
        .rf_register_no_o (rf_register_no),
        .rf_reg_data_o    (rf_reg_data),
        .wr_done_o        (wr_done),
        .wr_done_id_o     (wr_done_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    // RegisterFile model (captures on write rising edge) and write scoreboard
    always @(negedge clk) begin
        if (rf_write && !prev_write)
            regs[rf_register_no] = rf_reg_data;
        prev_write = rf_write;
        if (wr_done) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=id%0d expected=none", wr_done_id);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_id", 64'(wr_done_id), 64'(e.id));
                chk("sb_addr", 64'(rf_register_no), 64'(e.addr));
                chk("sb_data", 64'(rf_reg_data), 64'(e.data));
            end
        end
    end

    initial begin
        int n;
        int nz;
        for (int r = 0; r < 32; r++) regs[r] = 32'hFFFF_FFFF;
        reset      = 1'b1;
        req_valid  = '1;
        req_addr   = '0;
        req_data   = '0;
        init_start = 1'b0;

        // (1) reset values, then a single write from requester 0
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_write", 64'(rf_write), 64'(0));
        chk("rst_addr", 64'(rf_register_no), 64'(0));
        chk("rst_data", 64'(rf_reg_data), 64'(0));
        chk("rst_busy", 64'(init_busy), 64'(0));
        chk("rst_done", 64'(wr_done), 64'(0));
        chk("rst_done_id", 64'(wr_done_id), 64'(0));
        reset     = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("t1_ready", 64'(req_ready), 64'(4'b0001));
        sb.push_back('{id: 2'd0, addr: 5'd5, data: 32'hDEAD_BEEF});
        tick();
        req_valid = '0;
        chk("t1_setup_write", 64'(rf_write), 64'(0));
        chk("t1_setup_addr", 64'(rf_register_no), 64'(5));
        chk("t1_setup_data", 64'(rf_reg_data), 64'(32'hDEAD_BEEF));
        tick();
        chk("t1_strobe_write", 64'(rf_write), 64'(1));
        tick();
        chk("t1_idle_write", 64'(rf_write), 64'(0));
        chk("t1_reg5", 64'(regs[5]), 64'(32'hDEAD_BEEF));

        // (2) all four requesters valid continuously
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'(i + 1) * 32'h1111_1111);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % N;
            chk("t2_ready", 64'(req_ready), 64'(4'b0001 << g));
            sb.push_back('{id: 2'(g), addr: 5'(g + 1), data: 32'(g + 1) * 32'h1111_1111});
            tick();
            chk("t2_setup_write", 64'(rf_write), 64'(0));
            chk("t2_setup_addr", 64'(rf_register_no), 64'(g + 1));
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        // (3) init_start wins over a simultaneous request
        set_req(1, 5'd9, 32'hCAFE_0009);
        req_valid  = 4'b0010;
        init_start = 1'b1;
        #1;
        chk("t3_ready_init", 64'(req_ready), 64'(0));
        tick();
        init_start = 1'b0;
        chk("t3_busy", 64'(init_busy), 64'(1));
        chk("t3_ready_busy", 64'(req_ready), 64'(0));
        n = 0;
        while (init_busy && n < 200) begin
            n++;
            tick();
        end
        chk("t3_init_cycles", 64'(n), 64'(64));
        chk("t3_ready_after", 64'(req_ready), 64'(4'b0010));
        sb.push_back('{id: 2'd1, addr: 5'd9, data: 32'hCAFE_0009});
        tick();
        req_valid = '0;
        tick();
        tick();
        nz = 0;
        for (int r = 0; r < 32; r++) if (r != 9 && regs[r] != 32'd0) nz++;
        chk("t3_nonzero_regs", 64'(nz), 64'(0));
        chk("t3_reg5", 64'(regs[5]), 64'(0));
        chk("t3_reg9", 64'(regs[9]), 64'(32'hCAFE_0009));

        // (6) init_start during a sweep is ignored
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            n++;
            tick();
        end
        init_start = 1'b1;
        n++;
        tick();
        init_start = 1'b0;
        while (init_busy && n < 300) begin
            n++;
            tick();
        end
        chk("t6_init_cycles", 64'(n), 64'(64));
        chk("t6_reg9", 64'(regs[9]), 64'(0));

        // (4) pointer wraps from requester 3 to requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(3, 5'd20, 32'h0000_0033);
        req_valid = 4'b1000;
        #1;
        chk("t4_ready3", 64'(req_ready), 64'(4'b1000));
        sb.push_back('{id: 2'd3, addr: 5'd20, data: 32'h0000_0033});
        tick();
        set_req(0, 5'd21, 32'h0000_0044);
        req_valid = 4'b1001;
        tick();
        chk("t4_ready0", 64'(req_ready), 64'(4'b0001));
        sb.push_back('{id: 2'd0, addr: 5'd21, data: 32'h0000_0044});
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t4_reg21", 64'(regs[21]), 64'(32'h0000_0044));

        // (5) reset during SETUP aborts the write
        set_req(0, 5'd7, 32'h7777_7777);
        req_valid = 4'b0001;
        #1;
        chk("t5_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        reset     = 1'b1;
        chk("t5_setup_write", 64'(rf_write), 64'(0));
        tick();
        chk("t5_rst_write", 64'(rf_write), 64'(0));
        chk("t5_rst_addr", 64'(rf_register_no), 64'(0));
        chk("t5_rst_data", 64'(rf_reg_data), 64'(0));
        chk("t5_rst_busy", 64'(init_busy), 64'(0));
        chk("t5_rst_done", 64'(wr_done), 64'(0));
        chk("t5_rst_done_id", 64'(wr_done_id), 64'(0));
        chk("t5_rst_ready", 64'(req_ready), 64'(0));
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_reg7", 64'(regs[7]), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
